timer_ctrl_unit: RTL and testbench
==================================

Name: timer_ctrl_unit

Overview:
- General-purpose up-counting timer peripheral for the RV32I microcontroller.
- The datapath writes the prescaler and auto-reload values through its timer-register path (select code 1 = PSC, 2 = ARR).
- This block sequences start, count and reload, double-buffers the configuration, and raises a sticky interrupt plus an overrun flag for the core.

Parameters:
- TIM_W, 16, width of prescaler, auto-reload and counter.
- ARR_RST, 16'hFFFF, reset value of ARR preload and shadow.
- PSC_RST, 16'h0000, reset value of PSC preload and shadow.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- timer_en  in  1  level enable; a rising edge (re)starts the timer.
- opm  in  1  one-pulse mode; sampled in LOAD.
- psc_we  in  1  write strobe for the PSC preload.
- psc_wdata  in  TIM_W  PSC write data.
- arr_we  in  1  write strobe for the ARR preload.
- arr_wdata  in  TIM_W  ARR write data.
- irq_clr  in  1  one-cycle clear of irq and ovr.
- cnt  out  TIM_W  current counter value (registered).
- update_evt  out  1  one-cycle pulse on counter reload.
- irq  out  1  sticky update-interrupt flag.
- ovr  out  1  sticky overrun: an update occurred while irq was already set.
- running  out  1  high in RUN state.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - psc_pre and psc_sh = PSC_RST; arr_pre and arr_sh = ARR_RST.
  - psc_cnt = 0; cnt = 0; update_evt = irq = ovr = running = 0.
  - en_d (registered timer_en) = 0.
- Reset mid-count discards all progress; there is no pending-state retention.
- State machine (IDLE, LOAD, RUN):
  - IDLE -> LOAD when timer_en = 1 and en_d = 0 (rising edge).
  - LOAD (exactly 1 cycle): psc_sh <= psc_pre, arr_sh <= arr_pre, psc_cnt <= 0, cnt <= 0, opm_sh <= opm; go to RUN.
  - RUN -> IDLE when timer_en = 0. psc_cnt and cnt clear on entry to IDLE; irq and ovr are retained.
  - RUN -> IDLE on an update when opm_sh = 1. cnt = 0; a restart requires a new timer_en rising edge.
- Prescaler (RUN only):
  - psc_cnt increments each cycle.
  - When psc_cnt == psc_sh: psc_cnt <= 0 and tick = 1 (internal, combinational).
  - Division ratio is PSC+1; PSC = 0 gives a tick every cycle.
- Counter (on tick only):
  - If cnt == arr_sh: cnt <= 0, update_evt <= 1 (next cycle, one cycle wide), psc_sh <= psc_pre, arr_sh <= arr_pre.
  - Otherwise cnt <= cnt + 1.
  - Update period is (PSC+1)*(ARR+1) clocks; the first update occurs (PSC+1)*(ARR+1) cycles after the LOAD cycle.
  - ARR = 0 gives an update on every tick.
  - No arithmetic overflow is possible: cnt never exceeds arr_sh.
- Writes:
  - psc_we / arr_we always update the preload register.
  - In IDLE, the write also updates the shadow in the same cycle.
  - In RUN, the new value takes effect at the next update.
  - Write in the same cycle as an update: the shadow takes the new write data (forwarded), not the old preload.
  - psc_we and arr_we may be asserted together; the two registers are independent.
- Interrupt:
  - An update sets irq. If irq is already 1 at that update, ovr is set as well.
  - irq_clr clears both irq and ovr.
  - Set and clear in the same cycle: set wins (irq = 1, and ovr follows the set rule against the pre-clear irq).
- timer_en dropping in the same cycle as a tick: the stop wins; no update is generated.
- Writes during LOAD are captured into the shadow (the write overrides the LOAD copy).

Decomposition:
- Package timer_pkg:
  - typedef enum logic [1:0] {IDLE, LOAD, RUN} tim_state_t.
  - localparam TIM_W = 16.
  - localparams TIM_SEL_PSC = 8'h01 and TIM_SEL_ARR = 8'h02 (datapath select codes).
- One sub-module, timer_prescaler: psc_cnt register plus compare.
  - Ports: clk, reset, run, clr, psc_sh → tick.
- The top-level holds the FSM, shadow/preload registers, counter and flags.

Test Plan:
- Reset mid-RUN (PSC=1, ARR=3, reset asserted asynchronously between clock edges) -> all outputs 0 immediately; state IDLE; arr_sh = 16'hFFFF.
- IDLE write PSC=3, ARR=4; raise timer_en -> running = 1 after LOAD; update_evt pulses every 20 cycles; cnt steps 0..4 every 4 clocks; irq = 1 after the first update.
- RUN with PSC=0, ARR=9; write ARR=2 at cnt=5 -> the current period completes at 9; subsequent periods are 3 cycles; a write coinciding with update_evt takes effect immediately.
- No irq_clr across two updates (PSC=0, ARR=1) -> irq = 1 and ovr = 1 after the second update; irq_clr asserted on the update cycle -> irq = 1, ovr = 1 (set wins); irq_clr on a quiet cycle -> both 0.
- opm = 1, PSC=0, ARR=3 -> exactly one update_evt 4 cycles after LOAD, then IDLE with cnt = 0 while timer_en stays high; toggling timer_en low then high restarts.
- PSC=0, ARR=0 -> update_evt is high every cycle in RUN; dropping timer_en -> update_evt is 0 on the next cycle and cnt = 0.

Source files
------------

// File: rtl/timer_ctrl_unit_pkg.sv
// Shared types and constants for the up-counting timer peripheral.
package timer_pkg;

  localparam int TIM_W = 16;

  // Datapath register-select codes for the timer write path.
  localparam logic [7:0] TIM_SEL_PSC = 8'h01;
  localparam logic [7:0] TIM_SEL_ARR = 8'h02;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} tim_state_t;

endpackage

// File: rtl/timer_ctrl_unit_if.sv
// Configuration and status bundle between the core datapath and the timer.
interface timer_ctrl_unit_if;
  import timer_pkg::*;

  logic             timer_en;
  logic             opm;
  logic             psc_we;
  logic [TIM_W-1:0] psc_wdata;
  logic             arr_we;
  logic [TIM_W-1:0] arr_wdata;
  logic             irq_clr;
  logic [TIM_W-1:0] cnt;
  logic             update_evt;
  logic             irq;
  logic             ovr;
  logic             running;

  modport master (
    output timer_en, opm, psc_we, psc_wdata, arr_we, arr_wdata, irq_clr,
    input  cnt, update_evt, irq, ovr, running
  );

  modport slave (
    input  timer_en, opm, psc_we, psc_wdata, arr_we, arr_wdata, irq_clr,
    output cnt, update_evt, irq, ovr, running
  );

endinterface

// File: rtl/timer_ctrl_unit_prescaler.sv
// Prescaler: counts 0..psc_sh and emits a one-cycle tick on the terminal value.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clr,
  input  logic [TIM_W-1:0] psc_sh,
  output logic             tick
);

  logic [TIM_W-1:0] psc_cnt;

  assign tick = run && (psc_cnt == psc_sh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_cnt <= '0;
    end else if (clr) begin
      psc_cnt <= '0;
    end else if (run) begin
      psc_cnt <= tick ? '0 : psc_cnt + TIM_W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl_unit.sv
// Timer control unit: start/count/reload sequencing, double-buffered PSC/ARR,
// sticky update interrupt with overrun detection.
module timer_ctrl_unit
  import timer_pkg::*;
#(
  parameter logic [TIM_W-1:0] ARR_RST = 16'hFFFF,
  parameter logic [TIM_W-1:0] PSC_RST = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  timer_ctrl_unit_if.slave bus
);

  tim_state_t       state;
  tim_state_t       state_nxt;
  logic             en_d;
  logic             opm_sh;
  logic [TIM_W-1:0] psc_pre;
  logic [TIM_W-1:0] psc_sh;
  logic [TIM_W-1:0] arr_pre;
  logic [TIM_W-1:0] arr_sh;
  logic [TIM_W-1:0] cnt;
  logic             update_evt;
  logic             irq;
  logic             ovr;
  logic             run;
  logic             psc_clr;
  logic             tick;
  logic             wrap;
  logic             upd;

  // Dropping timer_en gates the tick, so a stop always beats a pending update.
  assign run     = (state == RUN) && bus.timer_en;
  assign psc_clr = (state != RUN);
  assign wrap    = (cnt == arr_sh);
  assign upd     = tick && wrap;

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .clr    (psc_clr),
    .psc_sh (psc_sh),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.timer_en && !en_d) state_nxt = LOAD;
      LOAD: state_nxt = RUN;
      RUN: begin
        if (!bus.timer_en)       state_nxt = IDLE;
        else if (upd && opm_sh)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      en_d   <= 1'b0;
      opm_sh <= 1'b0;
    end else begin
      state <= state_nxt;
      en_d  <= bus.timer_en;
      if (state == LOAD) opm_sh <= bus.opm;
    end
  end

  // A write landing on a shadow-load cycle is forwarded so it never gets lost
  // behind the stale preload value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_pre <= PSC_RST;
      psc_sh  <= PSC_RST;
      arr_pre <= ARR_RST;
      arr_sh  <= ARR_RST;
    end else begin
      if (bus.psc_we) psc_pre <= bus.psc_wdata;
      if (bus.arr_we) arr_pre <= bus.arr_wdata;

      if (bus.psc_we && (state != RUN || upd)) psc_sh <= bus.psc_wdata;
      else if (state == LOAD || upd)           psc_sh <= psc_pre;

      if (bus.arr_we && (state != RUN || upd)) arr_sh <= bus.arr_wdata;
      else if (state == LOAD || upd)           arr_sh <= arr_pre;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      update_evt <= 1'b0;
    end else begin
      update_evt <= upd;
      if (!run)      cnt <= '0;
      else if (tick) cnt <= wrap ? '0 : cnt + TIM_W'(1);
    end
  end

  // Update sets irq even when irq_clr arrives in the same cycle; ovr compares
  // against the irq value from before this update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
      ovr <= 1'b0;
    end else if (upd) begin
      irq <= 1'b1;
      if (irq) ovr <= 1'b1;
    end else if (bus.irq_clr) begin
      irq <= 1'b0;
      ovr <= 1'b0;
    end
  end

  assign bus.cnt        = cnt;
  assign bus.update_evt = update_evt;
  assign bus.irq        = irq;
  assign bus.ovr        = ovr;
  assign bus.running    = (state == RUN);

endmodule

// File: tb/tb_timer_ctrl_unit.sv
// Directed bench for timer_ctrl_unit with an elapsed-time reference model.
module tb_timer_ctrl_unit;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: counts RUN cycles elapsed in the current period and
  // derives the counter value from it.
  int          m_mode     = M_IDLE;
  bit          m_en_d     = 1'b0;
  bit          m_opm      = 1'b0;
  logic [15:0] m_ppre     = 16'h0000;
  logic [15:0] m_psh      = 16'h0000;
  logic [15:0] m_apre     = 16'hFFFF;
  logic [15:0] m_ash      = 16'hFFFF;
  longint      m_elapsed  = 0;
  bit          m_upd      = 1'b0;
  bit          m_irq      = 1'b0;
  bit          m_ovr      = 1'b0;
  logic [15:0] exp_cnt;
  logic        exp_run;

  timer_ctrl_unit_if bus ();

  timer_ctrl_unit #(
    .ARR_RST (16'hFFFF),
    .PSC_RST (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic longint periodLen(input logic [15:0] p, input logic [15:0] a);
    return (longint'(p) + 1) * (longint'(a) + 1);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic op, input logic clr);
    bus.timer_en = en;
    bus.opm      = op;
    bus.irq_clr  = clr;
  endtask

  task automatic writeRegs(input logic pwe, input logic [15:0] pd,
                           input logic awe, input logic [15:0] ad);
    bus.psc_we    = pwe;
    bus.psc_wdata = pd;
    bus.arr_we    = awe;
    bus.arr_wdata = ad;
    waitCycles(1);
    bus.psc_we = 1'b0;
    bus.arr_we = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.psc_we    = 1'b0;
    bus.psc_wdata = 16'h0;
    bus.arr_we    = 1'b0;
    bus.arr_wdata = 16'h0;

    fork
      begin : model_proc
        forever begin
          @(posedge clk or posedge reset);
          if (reset) begin
            m_mode = M_IDLE; m_en_d = 1'b0; m_opm = 1'b0;
            m_ppre = 16'h0000; m_psh = 16'h0000;
            m_apre = 16'hFFFF; m_ash = 16'hFFFF;
            m_elapsed = 0; m_upd = 1'b0; m_irq = 1'b0; m_ovr = 1'b0;
          end else begin
            m_upd = 1'b0;
            if (m_mode == M_IDLE) begin
              if (bus.psc_we) m_psh = bus.psc_wdata;
              if (bus.arr_we) m_ash = bus.arr_wdata;
              if (bus.timer_en && !m_en_d) m_mode = M_LOAD;
            end else if (m_mode == M_LOAD) begin
              m_psh = bus.psc_we ? bus.psc_wdata : m_ppre;
              m_ash = bus.arr_we ? bus.arr_wdata : m_apre;
              m_opm = bus.opm;
              m_elapsed = 0;
              m_mode = M_RUN;
            end else if (!bus.timer_en) begin
              m_mode = M_IDLE;
              m_elapsed = 0;
            end else begin
              m_elapsed++;
              if (m_elapsed == periodLen(m_psh, m_ash)) begin
                m_upd = 1'b1;
                m_elapsed = 0;
                m_psh = bus.psc_we ? bus.psc_wdata : m_ppre;
                m_ash = bus.arr_we ? bus.arr_wdata : m_apre;
                if (m_opm) m_mode = M_IDLE;
              end
            end
            if (m_upd) begin
              if (m_irq) m_ovr = 1'b1;
              m_irq = 1'b1;
            end else if (bus.irq_clr) begin
              m_irq = 1'b0;
              m_ovr = 1'b0;
            end
            if (bus.psc_we) m_ppre = bus.psc_wdata;
            if (bus.arr_we) m_apre = bus.arr_wdata;
            m_en_d = bus.timer_en;
          end
        end
      end
      begin : compare_proc
        forever begin
          @(negedge clk);
          exp_run = (m_mode == M_RUN);
          exp_cnt = exp_run ? 16'(m_elapsed / (longint'(m_psh) + 1)) : 16'h0;
          vectors++;
          if ({bus.cnt, bus.update_evt, bus.irq, bus.ovr, bus.running} !==
              {exp_cnt, m_upd, m_irq, m_ovr, exp_run}) begin
            miscompares++;
            $display("[TB] FAIL cycle_cmp t=%0t: got cnt=%0h upd=%b irq=%b ovr=%b run=%b, expected cnt=%0h upd=%b irq=%b ovr=%b run=%b",
                     $time, bus.cnt, bus.update_evt, bus.irq, bus.ovr, bus.running,
                     exp_cnt, m_upd, m_irq, m_ovr, exp_run);
          end
        end
      end
    join_none

    // Reset values
    waitCycles(2);
    checkOutput("rst_cnt", 32'(bus.cnt), 32'h0);
    checkOutput("rst_run", 32'(bus.running), 32'h0);
    checkOutput("rst_irq", 32'(bus.irq), 32'h0);
    checkOutput("rst_ovr", 32'(bus.ovr), 32'h0);
    checkOutput("rst_upd", 32'(bus.update_evt), 32'h0);
    reset = 1'b0;

    // Asynchronous reset in the middle of a count (PSC=1, ARR=3)
    writeRegs(1'b1, 16'd1, 1'b1, 16'd3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(7);
    checkOutput("mid_cnt", 32'(bus.cnt), 32'd2);
    checkOutput("mid_run", 32'(bus.running), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_cnt", 32'(bus.cnt), 32'h0);
    checkOutput("async_rst_run", 32'(bus.running), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);

    // PSC=3, ARR=4: one update per 20 cycles
    writeRegs(1'b1, 16'd3, 1'b1, 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("p2_load_run", 32'(bus.running), 32'h0);
    waitCycles(1);
    checkOutput("p2_run", 32'(bus.running), 32'h1);
    checkOutput("p2_cnt0", 32'(bus.cnt), 32'd0);
    waitCycles(4);
    checkOutput("p2_cnt1", 32'(bus.cnt), 32'd1);
    waitCycles(15);
    checkOutput("p2_cnt4", 32'(bus.cnt), 32'd4);
    checkOutput("p2_pre_upd", 32'(bus.update_evt), 32'h0);
    waitCycles(1);
    checkOutput("p2_upd1", 32'(bus.update_evt), 32'h1);
    checkOutput("p2_irq1", 32'(bus.irq), 32'h1);
    checkOutput("p2_ovr0", 32'(bus.ovr), 32'h0);
    waitCycles(1);
    checkOutput("p2_upd_pulse", 32'(bus.update_evt), 32'h0);
    waitCycles(19);
    checkOutput("p2_upd2", 32'(bus.update_evt), 32'h1);
    checkOutput("p2_ovr1", 32'(bus.ovr), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("p2_stop_run", 32'(bus.running), 32'h0);
    checkOutput("p2_stop_irq", 32'(bus.irq), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("p2_clr_irq", 32'(bus.irq), 32'h0);
    checkOutput("p2_clr_ovr", 32'(bus.ovr), 32'h0);

    // PSC=0, ARR=9 with ARR rewritten mid-period and on an update
    writeRegs(1'b1, 16'd0, 1'b1, 16'd9);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(7);
    checkOutput("p3_cnt5", 32'(bus.cnt), 32'd5);
    writeRegs(1'b0, 16'd0, 1'b1, 16'd2);
    waitCycles(3);
    checkOutput("p3_cnt9", 32'(bus.cnt), 32'd9);
    waitCycles(1);
    checkOutput("p3_upd_a", 32'(bus.update_evt), 32'h1);
    waitCycles(1);
    checkOutput("p3_cnt1", 32'(bus.cnt), 32'd1);
    waitCycles(2);
    checkOutput("p3_upd_b", 32'(bus.update_evt), 32'h1);
    waitCycles(2);
    writeRegs(1'b0, 16'd0, 1'b1, 16'd5);
    checkOutput("p3_upd_c", 32'(bus.update_evt), 32'h1);
    waitCycles(3);
    checkOutput("p3_fwd_noupd", 32'(bus.update_evt), 32'h0);
    checkOutput("p3_fwd_cnt3", 32'(bus.cnt), 32'd3);
    waitCycles(3);
    checkOutput("p3_fwd_upd", 32'(bus.update_evt), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // PSC=0, ARR=1: overrun, set-beats-clear, stop-beats-tick
    writeRegs(1'b1, 16'd0, 1'b1, 16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(4);
    checkOutput("p4_upd1", 32'(bus.update_evt), 32'h1);
    checkOutput("p4_ovr0", 32'(bus.ovr), 32'h0);
    waitCycles(2);
    checkOutput("p4_irq", 32'(bus.irq), 32'h1);
    checkOutput("p4_ovr1", 32'(bus.ovr), 32'h1);
    waitCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitCycles(1);
    checkOutput("p4_setwin_irq", 32'(bus.irq), 32'h1);
    checkOutput("p4_setwin_ovr", 32'(bus.ovr), 32'h1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("p4_quiet_irq", 32'(bus.irq), 32'h0);
    checkOutput("p4_quiet_ovr", 32'(bus.ovr), 32'h0);
    waitCycles(1);
    checkOutput("p4_stop_upd", 32'(bus.update_evt), 32'h0);
    checkOutput("p4_stop_irq", 32'(bus.irq), 32'h0);

    // One-pulse mode, PSC=0, ARR=3
    writeRegs(1'b1, 16'd0, 1'b1, 16'd3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(5);
    checkOutput("opm_cnt3", 32'(bus.cnt), 32'd3);
    checkOutput("opm_noupd", 32'(bus.update_evt), 32'h0);
    waitCycles(1);
    checkOutput("opm_upd", 32'(bus.update_evt), 32'h1);
    checkOutput("opm_idle", 32'(bus.running), 32'h0);
    checkOutput("opm_cnt0", 32'(bus.cnt), 32'd0);
    waitCycles(4);
    checkOutput("opm_stay_idle", 32'(bus.running), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(2);
    checkOutput("opm_restart", 32'(bus.running), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // PSC=0, ARR=0 with the ARR write landing in the LOAD cycle
    writeRegs(1'b0, 16'd0, 1'b1, 16'd7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    writeRegs(1'b0, 16'd0, 1'b1, 16'd0);
    checkOutput("p6_run", 32'(bus.running), 32'h1);
    checkOutput("p6_noupd", 32'(bus.update_evt), 32'h0);
    waitCycles(1);
    checkOutput("p6_upd_a", 32'(bus.update_evt), 32'h1);
    waitCycles(1);
    checkOutput("p6_upd_b", 32'(bus.update_evt), 32'h1);
    waitCycles(1);
    checkOutput("p6_upd_c", 32'(bus.update_evt), 32'h1);
    checkOutput("p6_cnt", 32'(bus.cnt), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("p6_stop_upd", 32'(bus.update_evt), 32'h0);
    checkOutput("p6_stop_cnt", 32'(bus.cnt), 32'd0);
    checkOutput("p6_stop_run", 32'(bus.running), 32'h0);

    waitCycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
